// File: rtl/elevator_pkg.sv
// Shared types and constants for the single-car elevator engine and the
// dual-elevator system built on top of it.
package elevator_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVE_UP   = 2'd1,
    MOVE_DOWN = 2'd2,
    DOOR_OPEN = 2'd3
  } state_e;

  typedef logic [1:0] floor_t;

  localparam int     NUM_FLOORS = 4;
  localparam floor_t TOP_FLOOR  = 2'd3;

endpackage

// File: rtl/elevator.sv
// Single-car elevator controller: accepts one request while idle, steps the
// car a floor per FLOOR_TICKS cycles, then holds the door for DOOR_TICKS.
module elevator
  import elevator_pkg::*;
#(
  parameter int FLOOR_TICKS = 4,
  parameter int DOOR_TICKS  = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] target_floor,
  input  logic       move_enable,
  output logic [1:0] current_floor,
  output logic       door_open,
  output logic       moving_up,
  output logic       moving_down,
  output logic       elevator_busy
);

  localparam int TMAX = (FLOOR_TICKS > DOOR_TICKS) ? FLOOR_TICKS : DOOR_TICKS;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [TW-1:0] FLOOR_LAST = TW'(FLOOR_TICKS - 1);
  localparam logic [TW-1:0] DOOR_LAST  = TW'(DOOR_TICKS - 1);

  state_e        state_q, state_d;
  floor_t        floor_q, floor_d;
  floor_t        tgt_q, tgt_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          move_enable_q;
  logic          req;
  floor_t        floor_up, floor_dn;

  assign req      = move_enable & ~move_enable_q;
  assign floor_up = floor_q + 2'd1;
  assign floor_dn = floor_q - 2'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      floor_q       <= '0;
      tgt_q         <= '0;
      timer_q       <= '0;
      move_enable_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      floor_q       <= floor_d;
      tgt_q         <= tgt_d;
      timer_q       <= timer_d;
      move_enable_q <= move_enable;
    end
  end

  // One timer serves both travel and door hold; it is cleared on every state change.
  always_comb begin
    state_d = state_q;
    floor_d = floor_q;
    tgt_d   = tgt_q;
    timer_d = timer_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          tgt_d   = target_floor;
          timer_d = '0;
          if (target_floor > floor_q)      state_d = MOVE_UP;
          else if (target_floor < floor_q) state_d = MOVE_DOWN;
          else                             state_d = DOOR_OPEN;
        end
      end
      MOVE_UP: begin
        if (timer_q == FLOOR_LAST) begin
          floor_d = floor_up;
          timer_d = '0;
          if (floor_up == tgt_q) state_d = DOOR_OPEN;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      MOVE_DOWN: begin
        if (timer_q == FLOOR_LAST) begin
          floor_d = floor_dn;
          timer_d = '0;
          if (floor_dn == tgt_q) state_d = DOOR_OPEN;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      DOOR_OPEN: begin
        if (timer_q == DOOR_LAST) begin
          timer_d = '0;
          state_d = IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign current_floor = floor_q;
  assign door_open     = (state_q == DOOR_OPEN);
  assign moving_up     = (state_q == MOVE_UP);
  assign moving_down   = (state_q == MOVE_DOWN);
  assign elevator_busy = (state_q != IDLE);

endmodule

// File: tb/tb_elevator.sv
// Directed bench for the elevator controller with default timing
// (FLOOR_TICKS=4, DOOR_TICKS=3).
module tb_elevator;

  logic       clk;
  logic       rst_n;
  logic [1:0] target_floor;
  logic       move_enable;
  logic [1:0] current_floor;
  logic       door_open;
  logic       moving_up;
  logic       moving_down;
  logic       elevator_busy;

  int checks;
  int errors;

  elevator #(.FLOOR_TICKS(4), .DOOR_TICKS(3)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .target_floor  (target_floor),
    .move_enable   (move_enable),
    .current_floor (current_floor),
    .door_open     (door_open),
    .moving_up     (moving_up),
    .moving_down   (moving_down),
    .elevator_busy (elevator_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Land 1 ns after the n-th following rising edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Snapshot of all outputs: floor, up, down, door, busy.
  task automatic chk_all(input string tag, input int fl, input int up,
                         input int dn, input int dr, input int bz);
    chk({tag, ".floor"}, current_floor, fl);
    chk({tag, ".up"},    moving_up,     up);
    chk({tag, ".down"},  moving_down,   dn);
    chk({tag, ".door"},  door_open,     dr);
    chk({tag, ".busy"},  elevator_busy, bz);
  endtask

  // Drop the strobe for one cycle, then raise it so the next edge is E0.
  task automatic request(input logic [1:0] fl);
    move_enable = 1'b0;
    step(1);
    target_floor = fl;
    move_enable  = 1'b1;
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    rst_n        = 1'b0;
    move_enable  = 1'b0;
    target_floor = 2'd0;

    step(2);
    chk_all("reset", 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    step(10);
    chk_all("idle10", 0, 0, 0, 0, 0);

    // G -> 2
    request(2'd2);
    step(1);
    chk_all("g2.e0", 0, 1, 0, 0, 1);
    step(4);
    chk_all("g2.e4", 1, 1, 0, 0, 1);
    step(3);
    chk_all("g2.e7", 1, 1, 0, 0, 1);
    step(1);
    chk_all("g2.e8", 2, 0, 0, 1, 1);
    step(2);
    chk_all("g2.e10", 2, 0, 0, 1, 1);
    step(1);
    chk_all("g2.e11", 2, 0, 0, 0, 0);
    step(5);
    chk_all("g2.hold", 2, 0, 0, 0, 0);

    // 2 -> 1
    request(2'd1);
    step(1);
    chk_all("d21.e0", 2, 0, 1, 0, 1);
    step(3);
    chk_all("d21.e3", 2, 0, 1, 0, 1);
    step(1);
    chk_all("d21.e4", 1, 0, 0, 1, 1);
    step(2);
    chk_all("d21.e6", 1, 0, 0, 1, 1);
    step(1);
    chk_all("d21.e7", 1, 0, 0, 0, 0);

    // Same floor
    request(2'd1);
    step(1);
    chk_all("same.e0", 1, 0, 0, 1, 1);
    step(1);
    chk_all("same.e1", 1, 0, 0, 1, 1);
    step(1);
    chk_all("same.e2", 1, 0, 0, 1, 1);
    step(1);
    chk_all("same.e3", 1, 0, 0, 0, 0);

    // 1 -> 0 to set up the 0 -> 3 trip
    request(2'd0);
    step(1);
    chk_all("d10.e0", 1, 0, 1, 0, 1);
    step(7);
    chk_all("d10.e7", 0, 0, 0, 0, 0);

    // 0 -> 3 with a rejected request mid-trip
    request(2'd3);
    step(1);
    chk_all("u03.e0", 0, 1, 0, 0, 1);
    move_enable = 1'b0;
    step(2);
    target_floor = 2'd0;
    move_enable  = 1'b1;
    step(1);
    move_enable = 1'b0;
    step(2);
    chk_all("u03.e5", 1, 1, 0, 0, 1);
    step(7);
    chk_all("u03.e12", 3, 0, 0, 1, 1);
    step(3);
    chk_all("u03.e15", 3, 0, 0, 0, 0);
    step(2);
    chk_all("u03.after", 3, 0, 0, 0, 0);

    // 3 -> 0
    request(2'd0);
    step(1);
    chk_all("d30.e0", 3, 0, 1, 0, 1);
    step(12);
    chk_all("d30.e12", 0, 0, 0, 1, 1);
    step(3);
    chk_all("d30.e15", 0, 0, 0, 0, 0);

    // Reset mid-trip between floors 1 and 2
    request(2'd3);
    step(1);
    step(5);
    chk_all("rst.pre", 1, 1, 0, 0, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("rst.async", 0, 0, 0, 0, 0);
    move_enable = 1'b0;
    step(1);
    rst_n = 1'b1;
    step(3);
    chk_all("rst.post", 0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/elevator.md
Name: elevator

Overview:
- Single-car controller for a 4-floor building (floors 0=G through 3, 2-bit encoding).
- Accepts one target request at a time and steps the car floor by floor using a fixed per-floor travel time.
- On arrival it holds the door open for a fixed time, then returns to idle.
- Used standalone, and as the per-car engine inside the dual-elevator system.

Parameters:
- FLOOR_TICKS, 4, clock cycles to travel one floor (>=1)
- DOOR_TICKS, 3, clock cycles the door stays open on arrival (>=1)

Ports:
- clk  input  1  system clock; all state changes on the rising edge
- rst_n  input  1  asynchronous active-low reset
- target_floor  input  2  requested floor; sampled only when a request is accepted
- move_enable  input  1  request strobe; a rising edge (0→1 between consecutive clock samples) is a request
- current_floor  output  2  floor the car is at, registered
- door_open  output  1  high while in DOOR_OPEN
- moving_up  output  1  high while in MOVE_UP
- moving_down  output  1  high while in MOVE_DOWN
- elevator_busy  output  1  high in any state other than IDLE

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-low (rst_n).
- Reset values (rst_n=0, asynchronous):
  - state=IDLE, current_floor=0, all flag outputs 0.
  - Latched target=0, travel/door timer=0, move_enable history register=0.
- Request detect: req = move_enable & ~move_enable_q, where move_enable_q is move_enable registered each cycle.
  - A level held high is not a new request.
  - req is honoured only in IDLE. In any other state req is dropped; it is not queued.
- IDLE, on req:
  - Latch target_floor into tgt and clear the timer.
  - tgt > current_floor → MOVE_UP.
  - tgt < current_floor → MOVE_DOWN.
  - tgt == current_floor → DOOR_OPEN. No movement.
- MOVE_UP / MOVE_DOWN, each clock:
  - If timer == FLOOR_TICKS-1: current_floor ±1, timer=0, and go to DOOR_OPEN if the new floor equals tgt.
  - Otherwise timer+1.
  - current_floor never wraps. tgt is fixed at acceptance, so the car never passes floor 3 or floor 0.
- DOOR_OPEN, each clock:
  - If timer == DOOR_TICKS-1: timer=0, go to IDLE.
  - Otherwise timer+1.
- Outputs are pure decodes of the registered state: exactly one of door_open/moving_up/moving_down is high when busy, none when idle.
- Latency, with the accepting edge as E0:
  - State changes at E0.
  - Floor n steps away is reached at E0 + n·FLOOR_TICKS; door_open rises on that same edge.
  - IDLE is reached DOOR_TICKS edges later.
  - Same-floor request: door_open high E0 .. E0+DOOR_TICKS-1.
- Changes to target_floor after acceptance are ignored until the next accepted request.
- Reset asserted mid-trip: immediately return to floor 0/IDLE. No state is retained.
- Timer width: clog2 of max(FLOOR_TICKS, DOOR_TICKS), minimum 1 bit.

Decomposition:
- elevator_pkg holds:
  - state typedef: IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN (2-bit encoding)
  - floor typedef: 2-bit
  - constants NUM_FLOORS=4, TOP_FLOOR=3
- The dual-elevator top also imports elevator_pkg.
- Single module, no sub-module; the shared travel/door timer is inline.

Test Plan:
- Reset: hold rst_n=0 → current_floor=0, all flags 0, busy=0. Release, then hold move_enable=0 for 10 cycles → no change.
- G→2 (defaults): rising move_enable with target=2.
  - moving_up=1 from E0.
  - floor=1 at E0+4; floor=2 and door_open=1 at E0+8.
  - busy=0 and idle at E0+11.
  - move_enable held high afterwards produces no re-trigger.
- 2→1: drop move_enable, then raise it with target=1.
  - moving_down=1 from E0.
  - floor=1 with door_open=1 at E0+4; idle at E0+7.
- Same floor: at floor 1, rising move_enable with target=1.
  - door_open=1 for 3 cycles, moving_up and moving_down stay 0, floor stays 1.
- Busy rejection: during a 0→3 trip, pulse move_enable with target=0 and change target_floor → car still reaches 3; request dropped.
- Mid-trip reset: assert rst_n=0 while moving_up=1 between floors 1 and 2 → outputs clear asynchronously (before the next edge) to floor 0, IDLE.
